mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// - Consumes the register bank read ports: opA <= Rdata1 (rs), opB <= Rdata2 (rt).
// - Executes MULT/MULTU/DIV/DIVU one bit per cycle (shift-add / restoring divide).
// - Holds HI/LO for MFHI/MFLO, which the write-back mux routes to the bank's Wdata.
// PARAMETERS
// N   32   operand width; HI and LO are each N bits. N >= 4.
// PORTS
// clk      in   1   clock, rising edge
// rst      in   1   reset; asynchronous, active-low
// start    in   1   begin operation op on opA/opB; sampled only in IDLE
// op       in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
// opA      in   N   rs operand (multiplicand / dividend)
// opB      in   N   rt operand (multiplier / divisor)
// mt_hi    in   1   MTHI: HI <= mt_data (IDLE only)
// mt_lo    in   1   MTLO: LO <= mt_data (IDLE only)
// mt_data  in   N   data for MTHI/MTLO
// busy     out  1   operation in progress (CALC or FIX)
// done     out  1   one-cycle pulse: HI/LO just updated by an operation
// div0     out  1   valid with done; 1 = divide with opB == 0
// hi       out  N   HI register (product[2N-1:N] / remainder)
// lo       out  N   LO register (product[N-1:0] / quotient)
// BEHAVIOUR
// - Reset (rst = 0, async): state IDLE, hi = lo = 0, busy = done = div0 = 0,
//   internal accumulators and counter = 0.
// - FSM states:
//   IDLE -> CALC  on start: latch |opA|, |opB|, result signs, and op; cnt = N-1.
//   CALC -> CALC  one iteration per cycle, cnt decrements.
//   CALC -> FIX   after the iteration with cnt == 0 (N iterations in total).
//   FIX  -> IDLE  apply sign fix; write hi/lo; done = 1 for one cycle.
// - Latency: start sampled at edge E gives hi/lo/done/div0 valid after edge E+N+1
//   (E+33 for N=32).
//   - busy = 1 from after edge E until after edge E+N+1. busy and done are never both 1.
// - Unsigned ops use the operands as-is. Signed ops take magnitudes.
//   - Product sign = sA ^ sB; 2N-bit negate in FIX when the sign is 1.
//   - Quotient sign = sA ^ sB; remainder sign = sA (truncating division).
// - Multiply: 2N-bit accumulator; add the multiplicand when the current multiplier LSB is 1, then shift.
// - Divide: restoring; shift the remainder left, bring in the next dividend bit, subtract if no borrow, set the quotient bit.
// - opB == 0 on DIV/DIVU: full N cycles run, result lo = {N{1}}, hi = opA (raw), div0 = 1.
//   No sign fix is applied.
// - DIV of -2^(N-1) by -1: lo = 2^(N-1) (wraps), hi = 0, div0 = 0.
// - start while busy: ignored; the operation in flight is unaffected.
// - start in the cycle done = 1: accepted, because the FSM is in IDLE.
// - mt_hi/mt_lo: write on the clock edge only in IDLE with start = 0.
//   - Ignored while busy.
//   - If start and mt_* are both high, start wins and mt_* is ignored.
//   - mt_hi and mt_lo may be asserted together; both registers take mt_data.
// - hi/lo hold their value between operations. They are not altered during CALC.
//   They change only in FIX, on MTHI/MTLO, or on reset.
// - Reset mid-operation: immediate return to IDLE with the reset values above; no done pulse.
// TESTING
// 1. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after start edge
// 2. MULT -3 (0xFFFFFFFD) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x7FFFFFFF*2 -> hi=0, lo=0xFFFFFFFE
// 3. DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=-3, hi=1
// 4. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234, div0=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0
// 5. second start + mt_lo during busy -> ignored, first result intact; MTHI 0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5
// 6. rst low at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, no done; next op completes normally

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative MIPS multiply/divide unit that owns the architectural HI/LO
//   registers. It handles one bit per cycle: shift-add for MULT/MULTU and a
//   restoring divider for DIV/DIVU. Signed operations run on magnitudes, and
//   the signs are applied in a single FIX cycle at the end.
// Ports
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   start_i    launch op_i on opa_i/opb_i (sampled only in IDLE)
//   op_i       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opa_i      rs operand (multiplicand / dividend)
//   opb_i      rt operand (multiplier / divisor)
//   mt_hi_i    MTHI: HI <= mt_data_i (IDLE, no start)
//   mt_lo_i    MTLO: LO <= mt_data_i (IDLE, no start)
//   mt_data_i  MTHI/MTLO data
//   busy_o     operation in flight (CALC or FIX)
//   done_o     one-cycle pulse when an operation has just written HI/LO
//   div0_o     qualifies done_o: the divide had a zero divisor
//   hi_o/lo_o  HI/LO registers
module mips_muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] opa_i,
  input  logic [N-1:0] opb_i,
  input  logic         mt_hi_i,
  input  logic         mt_lo_i,
  input  logic [N-1:0] mt_data_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         div0_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e         state_q, state_d;
  // For a multiply, acc holds {partial product, remaining multiplier bits}.
  // For a divide, acc holds {partial remainder, dividend/quotient bits}.
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   m_q, m_d;         // multiplicand |A|, or divisor |B|
  logic [N-1:0]   araw_q, araw_d;   // unmodified dividend, used for the div-by-zero result
  logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           div_q, div_d;
  logic           sq_q, sq_d;       // product or quotient sign
  logic           sr_q, sr_d;       // remainder sign
  logic           bz_q, bz_d;       // divisor was zero
  logic           done_q, done_d;
  logic           div0_q, div0_d;

  logic           sa, sb;
  logic [N-1:0]   mag_a, mag_b;
  logic [N:0]     msum;
  logic [N:0]     dsh, ddiff;
  logic           nb;
  logic [2*N-1:0] mult_nxt, div_nxt, prod_neg;
  logic [N-1:0]   quo, rem;

  // Only the signed ops (op_i[0] = 1) treat the operand MSBs as sign bits.
  assign sa    = op_i[0] & opa_i[N-1];
  assign sb    = op_i[0] & opb_i[N-1];
  assign mag_a = sa ? -opa_i : opa_i;
  assign mag_b = sb ? -opb_i : opb_i;

  // Multiply step: add into the upper half when the multiplier LSB is set,
  // then shift the whole accumulator right. The carry becomes the new MSB.
  assign msum     = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? m_q : {N{1'b0}})};
  assign mult_nxt = {msum, acc_q[N-1:1]};

  // Divide step: shift the next dividend bit into the remainder and try the
  // subtraction. The subtraction is kept only when it does not borrow.
  assign dsh     = {acc_q[2*N-1:N], acc_q[N-1]};
  assign ddiff   = dsh - {1'b0, m_q};
  assign nb      = ~ddiff[N];
  assign div_nxt = {(nb ? ddiff[N-1:0] : dsh[N-1:0]), acc_q[N-2:0], nb};

  assign prod_neg = -acc_q;
  assign quo      = acc_q[N-1:0];
  assign rem      = acc_q[2*N-1:N];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    div0_d  = div0_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          cnt_d   = CW'(N-1);
          div_d   = op_i[1];
          sq_d    = sa ^ sb;
          sr_d    = sa;
          bz_d    = (opb_i == '0);
          araw_d  = opa_i;
          if (op_i[1]) begin
            m_d   = mag_b;
            acc_d = {{N{1'b0}}, mag_a};
          end else begin
            m_d   = mag_a;
            acc_d = {{N{1'b0}}, mag_b};
          end
        end else begin
          if (mt_hi_i) hi_d = mt_data_i;
          if (mt_lo_i) lo_d = mt_data_i;
        end
      end
      S_CALC: begin
        acc_d = div_q ? div_nxt : mult_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        div0_d  = div_q & bz_q;
        if (!div_q) begin
          {hi_d, lo_d} = sq_q ? prod_neg : acc_q;
        end else if (bz_q) begin
          lo_d = {N{1'b1}};
          hi_d = araw_q;
        end else begin
          lo_d = sq_q ? -quo : quo;
          hi_d = sr_q ? -rem : rem;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign div0_o = div0_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Testbench for mips_muldiv_unit (N = 32): a table of directed MULT/DIV
// vectors, followed by hand-written sequences for busy, MTHI/MTLO and reset.
module tb_mips_muldiv_unit;

  logic        clk, rst_n, start, mt_hi, mt_lo;
  logic [1:0]  op;
  logic [31:0] opa, opb, mt_data;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mips_muldiv_unit #(.N(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
    .opa_i(opa), .opb_i(opb), .mt_hi_i(mt_hi), .mt_lo_i(mt_lo),
    .mt_data_i(mt_data), .busy_o(busy), .done_o(done), .div0_o(div0),
    .hi_o(hi), .lo_o(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        d0;
  } vec_t;

  localparam int NV = 14;
  vec_t tv[NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Launches one operation on the next edge, then waits for done within a
  // bounded number of edges. lat is the number of edges after the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] lo_prev;

    tv[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[2]  = '{2'b01, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 1'b0};
    tv[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tv[4]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[5]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tv[6]  = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    tv[7]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tv[8]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    tv[9]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tv[10] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tv[11] = '{2'b00, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
    tv[12] = '{2'b10, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0};
    tv[13] = '{2'b11, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

    rst_n = 1'b0; start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    op = 2'b00; opa = '0; opb = '0; mt_data = '0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_div0", div0, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Each operation starts in the cycle where the previous done is high.
    for (int i = 0; i < NV; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, 33);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      chk($sformatf("v%0d_hi", i), hi, tv[i].hi);
      chk($sformatf("v%0d_lo", i), lo, tv[i].lo);
      chk($sformatf("v%0d_div0", i), div0, tv[i].d0);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);

    // A start and an MTLO issued while busy must both be ignored.
    op = 2'b10; opa = 32'd100; opb = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = 2'b00; opa = 32'd3; opb = 32'd3; start = 1'b1; mt_lo = 1'b1; mt_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; mt_lo = 1'b0;
    chk("busy_mt_lo_ignored", lo, 32'h00000002);
    lat = 6;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start_latency", lat, 33);
    chk("busy_start_hi", hi, 2);
    chk("busy_start_lo", lo, 14);

    // MTHI in IDLE.
    mt_hi = 1'b1; mt_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mt_hi = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_lo_kept", lo, 14);
    // MTHI and MTLO together.
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h0BADF00D;
    @(posedge clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b0;
    chk("mtboth_hi", hi, 32'h0BADF00D);
    chk("mtboth_lo", lo, 32'h0BADF00D);

    // start wins over MTLO. HI/LO must hold through CALC.
    lo_prev = lo;
    op = 2'b00; opa = 32'd3; opb = 32'd4; start = 1'b1; mt_lo = 1'b1; mt_data = 32'h11111111;
    @(posedge clk); #1;
    start = 1'b0; mt_lo = 1'b0;
    chk("start_wins_lo_hold", lo, lo_prev);
    chk("start_wins_busy", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("start_wins_latency", lat, 33);
    chk("start_wins_hi", hi, 0);
    chk("start_wins_lo", lo, 12);

    // Reset in the middle of a divide.
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h5A5A5A5A;
    @(posedge clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b0;
    op = 2'b11; opa = 32'd1000; opb = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    #20;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run_op(2'b11, 32'd1000, 32'd9, lat);
    chk("post_rst_latency", lat, 33);
    chk("post_rst_hi", hi, 1);
    chk("post_rst_lo", lo, 111);
    chk("post_rst_div0", div0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
